fifo_read_streamer: RTL and testbench

- Read-side drain engine for the asynchronous FIFO.
- Sits in the read clock domain. Drives the FIFO's read-enable, captures read data one cycle later, and presents it as a valid/ready stream to downstream logic.
- Holds data in a 2-entry buffer so downstream backpressure never drops or duplicates a word, while sustaining 1 word/cycle.
- Also counts delivered words and reports buffer occupancy.

---
 rtl/fifo_read_streamer_pkg.sv | 19 +
 rtl/fifo_read_streamer_stream_skid_buf.sv | 89 ++++++++
 rtl/fifo_read_streamer.sv | 94 +++++++++
 tb/tb_fifo_read_streamer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_read_streamer_pkg.sv
// ---------------------------------------------------------------------------
// fifo_read_streamer_pkg
// Shared constants for the FIFO read-side streamer: buffer depth and the
// occupancy encoding used by the 2-entry stream buffer.
// No ports (package).
// ---------------------------------------------------------------------------
package fifo_read_streamer_pkg;

   // Occupancy of the stream buffer doubles as its state encoding.
   typedef logic [1:0] occ_t;

   localparam occ_t OCC_EMPTY = 2'd0;
   localparam occ_t OCC_ONE   = 2'd1;
   localparam occ_t OCC_TWO   = 2'd2;

   // Buffer depth, sized for comparison against occupancy + in-flight - pop.
   localparam logic [2:0] BUF_DEPTH = 3'd2;

endpackage

// File: rtl/fifo_read_streamer_stream_skid_buf.sv
// ---------------------------------------------------------------------------
// stream_skid_buf
// Two-entry registered buffer with push/pop. The head entry drives the
// stream data directly from a register.
// Ports:
//   clk_i        clock (posedge)
//   rst_n_i      asynchronous active-low reset
//   clear_i      synchronous flush (dominant over push/pop)
//   push_i       write push_data_i at the tail
//   push_data_i  word to write
//   pop_i        remove the head (caller guarantees occupancy != 0)
//   head_o       registered head entry
//   level_o      occupancy 0..2
// ---------------------------------------------------------------------------
module stream_skid_buf
   import fifo_read_streamer_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  clear_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] head_o,
   output occ_t                  level_o
);

   logic [DATA_WIDTH-1:0] entry0_q, entry0_d;
   logic [DATA_WIDTH-1:0] entry1_q, entry1_d;
   occ_t                  level_q, level_d;

   always_comb begin
      entry0_d = entry0_q;
      entry1_d = entry1_q;
      level_d  = level_q;
      if (clear_i) begin
         level_d = OCC_EMPTY;
      end else begin
         case (level_q)
            OCC_EMPTY: begin
               if (push_i) begin
                  entry0_d = push_data_i;
                  level_d  = OCC_ONE;
               end
            end
            OCC_ONE: begin
               if (push_i && pop_i) begin
                  // Head replaced by the incoming word.
                  entry0_d = push_data_i;
               end else if (push_i) begin
                  entry1_d = push_data_i;
                  level_d  = OCC_TWO;
               end else if (pop_i) begin
                  level_d = OCC_EMPTY;
               end
            end
            OCC_TWO: begin
               if (pop_i) begin
                  entry0_d = entry1_q;
                  level_d  = OCC_ONE;
                  if (push_i) begin
                     entry1_d = push_data_i;
                     level_d  = OCC_TWO;
                  end
               end
            end
            default: level_d = OCC_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         entry0_q <= '0;
         entry1_q <= '0;
         level_q  <= OCC_EMPTY;
      end else begin
         entry0_q <= entry0_d;
         entry1_q <= entry1_d;
         level_q  <= level_d;
      end
   end

   assign head_o  = entry0_q;
   assign level_o = level_q;

endmodule

// File: rtl/fifo_read_streamer.sv
// ---------------------------------------------------------------------------
// fifo_read_streamer
// Read-side drain engine for an asynchronous FIFO. Issues reads, captures the
// word one cycle later into a 2-entry buffer and presents it as a
// valid/ready stream; counts delivered words.
// Ports:
//   Clk            read-domain clock
//   Rst_n_in       asynchronous active-low reset
//   Empty_in       FIFO empty flag
//   Data_in        FIFO read data (valid the cycle after a read)
//   ReadEn_out     FIFO read enable
//   Clear_in       synchronous flush of buffer, in-flight read and counter
//   Valid_out      stream word available
//   Ready_in       downstream accepts
//   Data_out       stream data (buffer head)
//   Level_out      buffer occupancy 0..2
//   WordCount_out  delivered-word counter (wraps)
// ---------------------------------------------------------------------------
module fifo_read_streamer
   import fifo_read_streamer_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   Clk,
   input  logic                   Rst_n_in,
   input  logic                   Empty_in,
   input  logic [DATA_WIDTH-1:0]  Data_in,
   output logic                   ReadEn_out,
   input  logic                   Clear_in,
   output logic                   Valid_out,
   input  logic                   Ready_in,
   output logic [DATA_WIDTH-1:0]  Data_out,
   output logic [1:0]             Level_out,
   output logic [COUNT_WIDTH-1:0] WordCount_out
);

   // run_q holds off reads until the first edge after reset release, so no
   // read is issued while reset is asserted or on the releasing edge.
   logic                   run_q;
   logic                   inflight_q, inflight_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;

   occ_t                   level_w;
   logic                   pop_w;
   logic [2:0]             occ_sum_w;

   assign Valid_out = (level_w != OCC_EMPTY);
   assign pop_w     = Valid_out & Ready_in;

   // Slots committed after this edge; a read may issue only if one is free,
   // which makes a capture into a full buffer impossible.
   assign occ_sum_w  = {1'b0, level_w} + {2'b00, inflight_q} - {2'b00, pop_w};
   assign ReadEn_out = run_q & ~Empty_in & ~Clear_in & (occ_sum_w < BUF_DEPTH);

   always_comb begin
      inflight_d = ReadEn_out;
      count_d    = count_q;
      if (Clear_in) begin
         count_d = '0;
      end else if (pop_w) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n_in) begin
      if (!Rst_n_in) begin
         run_q      <= 1'b0;
         inflight_q <= 1'b0;
         count_q    <= '0;
      end else begin
         run_q      <= 1'b1;
         inflight_q <= inflight_d;
         count_q    <= count_d;
      end
   end

   stream_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buf (
      .clk_i       (Clk),
      .rst_n_i     (Rst_n_in),
      .clear_i     (Clear_in),
      .push_i      (inflight_q & ~Clear_in),
      .push_data_i (Data_in),
      .pop_i       (pop_w & ~Clear_in),
      .head_o      (Data_out),
      .level_o     (level_w)
   );

   assign Level_out     = level_w;
   assign WordCount_out = count_q;

endmodule

// File: tb/tb_fifo_read_streamer.sv
// ---------------------------------------------------------------------------
// tb_fifo_read_streamer
// Drives a FIFO model into two streamer instances (16-bit and 4-bit counter)
// and compares every cycle against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_fifo_read_streamer;

   logic        Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic        Rst_n_in, Empty_in, Clear_in, Ready_in;
   logic [7:0]  Data_in;

   logic        ReadEn_out, Valid_out;
   logic [7:0]  Data_out;
   logic [1:0]  Level_out;
   logic [15:0] WordCount_out;

   logic        re4, valid4;
   logic [7:0]  data4;
   logic [1:0]  level4;
   logic [3:0]  count4;

   fifo_read_streamer #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
      .Clk(Clk), .Rst_n_in(Rst_n_in), .Empty_in(Empty_in), .Data_in(Data_in),
      .ReadEn_out(ReadEn_out), .Clear_in(Clear_in), .Valid_out(Valid_out),
      .Ready_in(Ready_in), .Data_out(Data_out), .Level_out(Level_out),
      .WordCount_out(WordCount_out)
   );

   fifo_read_streamer #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut4 (
      .Clk(Clk), .Rst_n_in(Rst_n_in), .Empty_in(Empty_in), .Data_in(Data_in),
      .ReadEn_out(re4), .Clear_in(Clear_in), .Valid_out(valid4),
      .Ready_in(Ready_in), .Data_out(data4), .Level_out(level4),
      .WordCount_out(count4)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] fifo_q[$];     // words still in the source FIFO
   logic [7:0] buf_m[$];      // words held by the streamer, head first
   logic [7:0] delivered[$];  // words actually handed over by the DUT
   logic       inflight_m;
   logic [7:0] pend_m;
   logic       run_m;
   int         count_m;
   int         re_pulses;
   logic [7:0] next_word;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_readen"}, 32'(ReadEn_out), 32'd0);
      check_eq({tag, "_valid"},  32'(Valid_out), 32'd0);
      check_eq({tag, "_data"},   32'(Data_out), 32'd0);
      check_eq({tag, "_level"},  32'(Level_out), 32'd0);
      check_eq({tag, "_count"},  32'(WordCount_out), 32'd0);
      check_eq({tag, "_count4"}, 32'(count4), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Rst_n_in = 1'b0;
      Clear_in = 1'b0;
      Ready_in = 1'b1;
      Empty_in = (fifo_q.size() == 0);
      Data_in  = 8'($urandom);
      #1;
      check_reset_outputs("rst_a");
      buf_m.delete();
      inflight_m = 1'b0;
      count_m    = 0;
      run_m      = 1'b0;
      @(negedge Clk);
      #1;
      check_reset_outputs("rst_b");
      Rst_n_in = 1'b1;
      #1;
      check_eq("rst_release_readen", 32'(ReadEn_out), 32'd0);
      // The next edge enables issuing; nothing else can change on it.
      run_m = 1'b1;
      $display("reset done, fifo holds %0d words", fifo_q.size());
   endtask

   task automatic cycle(input logic rdy, input logic clr);
      logic valid_e, pop_e, re_e;
      int   occ;
      @(negedge Clk);
      Ready_in = rdy;
      Clear_in = clr;
      Empty_in = (fifo_q.size() == 0);
      Data_in  = inflight_m ? pend_m : 8'($urandom);
      #1;
      valid_e = (buf_m.size() != 0);
      pop_e   = valid_e && rdy;
      occ     = buf_m.size() + int'(inflight_m) - int'(pop_e);
      re_e    = run_m && (fifo_q.size() != 0) && !clr && (occ < 2);

      check_eq("valid",  32'(Valid_out), 32'(valid_e));
      check_eq("level",  32'(Level_out), 32'(buf_m.size()));
      check_eq("readen", 32'(ReadEn_out), 32'(re_e));
      check_eq("readen4", 32'(re4), 32'(re_e));
      check_eq("count",  32'(WordCount_out), 32'(count_m % 65536));
      check_eq("count4", 32'(count4), 32'(count_m % 16));
      if (valid_e) check_eq("data", 32'(Data_out), 32'(buf_m[0]));

      if (ReadEn_out) re_pulses++;
      if (Valid_out && rdy && !clr) delivered.push_back(Data_out);

      $display("cyc rdy=%0b clr=%0b empty=%0b re=%0b valid=%0b data=%02h lvl=%0d cnt=%0d",
               rdy, clr, Empty_in, ReadEn_out, Valid_out, Data_out, Level_out, WordCount_out);

      // Model update for the coming edge.
      if (clr) begin
         buf_m.delete();
         inflight_m = 1'b0;
         count_m    = 0;
      end else begin
         if (pop_e) begin
            void'(buf_m.pop_front());
            count_m++;
         end
         if (inflight_m) buf_m.push_back(pend_m);
         inflight_m = re_e;
         if (re_e) pend_m = fifo_q.pop_front();
      end
      check_eq("no_overflow", 32'(buf_m.size() <= 2), 32'd1);
   endtask

   initial begin
      Rst_n_in   = 1'b0;
      Empty_in   = 1'b1;
      Clear_in   = 1'b0;
      Ready_in   = 1'b0;
      Data_in    = '0;
      inflight_m = 1'b0;
      pend_m     = '0;
      run_m      = 1'b0;
      count_m    = 0;
      re_pulses  = 0;
      next_word  = 8'h30;

      // Reset with data waiting, then streaming 0x10..0x1F.
      for (int i = 0; i < 16; i++) fifo_q.push_back(8'(8'h10 + i));
      do_reset();
      delivered.delete();
      repeat (20) cycle(1'b1, 1'b0);
      check_eq("stream_words", 32'(delivered.size()), 32'd16);
      for (int i = 0; i < 16 && i < delivered.size(); i++)
         check_eq("stream_order", 32'(delivered[i]), 32'(8'h10 + i));
      check_eq("stream_count", 32'(count_m), 32'd16);

      // Backpressure mid-stream.
      for (int i = 0; i < 16; i++) fifo_q.push_back(8'(8'h20 + i));
      delivered.delete();
      repeat (4) cycle(1'b1, 1'b0);
      repeat (5) cycle(1'b0, 1'b0);
      repeat (20) cycle(1'b1, 1'b0);
      check_eq("bp_words", 32'(delivered.size()), 32'd16);
      for (int i = 0; i < 16 && i < delivered.size(); i++)
         check_eq("bp_order", 32'(delivered[i]), 32'(8'h20 + i));
      check_eq("wrap4_after_32", 32'(count4), 32'(count_m % 16));

      // Empty boundary: exactly three words.
      cycle(1'b1, 1'b1);
      fifo_q.push_back(8'hA0);
      fifo_q.push_back(8'hA1);
      fifo_q.push_back(8'hA2);
      re_pulses = 0;
      delivered.delete();
      repeat (8) cycle(1'b1, 1'b0);
      check_eq("empty_pulses", 32'(re_pulses), 32'd3);
      check_eq("empty_words", 32'(delivered.size()), 32'd3);
      for (int i = 0; i < 3 && i < delivered.size(); i++)
         check_eq("empty_order", 32'(delivered[i]), 32'(8'hA0 + i));

      // Clear with a read in flight and one word buffered.
      fifo_q.push_back(8'hB0);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      fifo_q.push_back(8'hB1);
      cycle(1'b0, 1'b0);
      check_eq("clr_pre_level", 32'(Level_out), 32'd1);
      delivered.delete();
      cycle(1'b0, 1'b1);
      repeat (3) cycle(1'b1, 1'b0);
      check_eq("clr_nothing_delivered", 32'(delivered.size()), 32'd0);
      check_eq("clr_count", 32'(WordCount_out), 32'd0);

      // Randomized traffic with one reset in the middle.
      for (int i = 0; i < 900; i++) begin
         if (i == 450) do_reset();
         if (fifo_q.size() < 3 && $urandom_range(0, 3) == 0) begin
            int n;
            n = int'($urandom_range(1, 6));
            for (int k = 0; k < n; k++) begin
               fifo_q.push_back(next_word);
               next_word = next_word + 8'd1;
            end
         end
         cycle(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 39) == 0));
      end
      check_eq("final_count4", 32'(count4), 32'(count_m % 16));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
